// File: rtl/i2c_master_read_burst.sv
// I2C master read, data phase only: clocks in 1..MAX_BYTES bytes, ACKs all but the last (NACK),
// and presents each byte on a valid/ready handshake while holding SCL low as backpressure.
module i2c_master_read_burst #(
    parameter int CLK_DIV         = 4,
    parameter int MAX_BYTES       = 16,
    parameter int COUNT_W         = 5,
    parameter int STRETCH_TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic [COUNT_W-1:0] byte_count,
    output logic [7:0]         data,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               last,
    output logic               busy,
    output logic               finish,
    output logic               error,
    output logic               scl_oe,
    input  logic               scl_in,
    output logic               sda_oe,
    input  logic               sda_in
);

    localparam int PW = $clog2(2 * CLK_DIV) + 1;
    localparam int SW = $clog2(STRETCH_TIMEOUT + 1);
    localparam logic [PW-1:0] PHASE_END    = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] SAMPLE_AT    = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, BIT_LOW, BIT_RISE, BIT_HIGH, HOLD,
        ACK_LOW, ACK_RISE, ACK_HIGH, ACK_HOLD, DONE, ABORT
    } state_t;

    state_t             state;
    logic [PW-1:0]      phase;
    logic [SW-1:0]      stretch;
    logic [2:0]         bit_idx;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] byte_num;
    logic [7:0]         shift;
    logic               final_byte;
    logic               go_ok;

    assign final_byte = (byte_num == count_q);
    assign go_ok      = (byte_count != '0) && (byte_count <= COUNT_W'(MAX_BYTES));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            stretch    <= '0;
            bit_idx    <= '0;
            count_q    <= '0;
            byte_num   <= '0;
            shift      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            error      <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            finish <= 1'b0;
            error  <= 1'b0;
            case (state)
                IDLE: begin
                    scl_oe <= 1'b0;
                    sda_oe <= 1'b0;
                    if (go) begin
                        if (go_ok) begin
                            count_q  <= byte_count;
                            byte_num <= COUNT_W'(1);
                            bit_idx  <= 3'd7;
                            phase    <= '0;
                            busy     <= 1'b1;
                            scl_oe   <= 1'b1;
                            state    <= BIT_LOW;
                        end else begin
                            finish <= 1'b1;
                            error  <= 1'b1;
                            state  <= ABORT;
                        end
                    end
                end
                BIT_LOW, ACK_LOW: begin
                    if (phase == PHASE_END) begin
                        scl_oe  <= 1'b0;
                        stretch <= '0;
                        state   <= (state == BIT_LOW) ? BIT_RISE : ACK_RISE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                // The clock that first sees SCL high counts as the first clock of the high phase.
                BIT_RISE, ACK_RISE: begin
                    if (scl_in) begin
                        phase <= PW'(1);
                        state <= (state == BIT_RISE) ? BIT_HIGH : ACK_HIGH;
                        if (CLK_DIV == 1 && state == BIT_RISE)
                            shift <= {shift[6:0], sda_in};
                    end else if (stretch >= STRETCH_LAST) begin
                        finish <= 1'b1;
                        error  <= 1'b1;
                        busy   <= 1'b0;
                        sda_oe <= 1'b0;
                        state  <= ABORT;
                    end else begin
                        stretch <= stretch + 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if (phase == SAMPLE_AT)
                        shift <= {shift[6:0], sda_in};
                    if (phase == PHASE_END) begin
                        scl_oe <= 1'b1;
                        phase  <= '0;
                        if (bit_idx == 3'd0) begin
                            data       <= shift;
                            data_valid <= 1'b1;
                            last       <= final_byte;
                            state      <= HOLD;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                            state   <= BIT_LOW;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                HOLD: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        last       <= 1'b0;
                        sda_oe     <= ~final_byte;
                        phase      <= '0;
                        state      <= ACK_LOW;
                    end
                end
                ACK_HIGH: begin
                    if (phase == PHASE_END) begin
                        scl_oe <= 1'b1;
                        state  <= ACK_HOLD;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                // SDA hold clock doubles as the first clock of the next byte's low phase.
                ACK_HOLD: begin
                    sda_oe <= 1'b0;
                    if (final_byte) begin
                        scl_oe <= 1'b0;
                        busy   <= 1'b0;
                        finish <= 1'b1;
                        state  <= DONE;
                    end else begin
                        byte_num <= byte_num + 1'b1;
                        bit_idx  <= 3'd7;
                        phase    <= PW'(1);
                        state    <= BIT_LOW;
                    end
                end
                DONE, ABORT: state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_read_burst.sv
// Bench for i2c_master_read_burst: open-drain bus with a byte-serving slave model, a scoreboard of
// expected bytes, a vector table of bursts, and hand-written timeout and mid-burst reset sequences.
module tb_i2c_master_read_burst;

    localparam int CLK_DIV = 4;
    localparam int MAX_BYTES = 16;
    localparam int COUNT_W = 5;
    localparam int STRETCH_TIMEOUT = 64;

    logic               clock = 1'b0;
    logic               reset;
    logic               go;
    logic [COUNT_W-1:0] byte_count;
    logic [7:0]         data;
    logic               data_valid;
    logic               data_ready;
    logic               last;
    logic               busy;
    logic               finish;
    logic               error;
    logic               scl_oe;
    logic               scl_in;
    logic               sda_oe;
    logic               sda_in;

    i2c_master_read_burst #(
        .CLK_DIV(CLK_DIV),
        .MAX_BYTES(MAX_BYTES),
        .COUNT_W(COUNT_W),
        .STRETCH_TIMEOUT(STRETCH_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .byte_count(byte_count),
        .data(data), .data_valid(data_valid), .data_ready(data_ready), .last(last),
        .busy(busy), .finish(finish), .error(error),
        .scl_oe(scl_oe), .scl_in(scl_in), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    always #5 clock = ~clock;

    // Slave model: presents bit cur_idx (9 slots per byte, slot 8 = ACK) while SCL is low.
    logic [127:0] sl_bytes;
    int           stretch_at;
    logic         stuck;
    logic         slave_clr;
    logic         prev_scl;
    int           rise_cnt;
    int           cur_idx;
    int           hold_cnt;
    logic         stretch_hold;
    logic         slave_sda_low;

    assign stretch_hold = (cur_idx == stretch_at) && (hold_cnt < 20);
    assign scl_in = ~scl_oe & ~stuck & ~stretch_hold;
    assign sda_in = ~sda_oe & ~slave_sda_low;

    always_comb begin
        logic [6:0] bi;
        bi = 7'((cur_idx / 9) * 8 + 7 - (cur_idx % 9));
        slave_sda_low = 1'b0;
        if ((cur_idx % 9) < 8 && (cur_idx / 9) < 16)
            slave_sda_low = ~sl_bytes[bi];
    end

    always @(posedge clock) begin
        prev_scl <= scl_in;
        if (slave_clr) begin
            rise_cnt <= 0;
            cur_idx  <= 0;
            hold_cnt <= 0;
        end else begin
            if (!prev_scl && scl_in) rise_cnt <= rise_cnt + 1;
            if (prev_scl && !scl_in) cur_idx <= rise_cnt;
            if (!scl_oe && cur_idx == stretch_at && hold_cnt < 20) hold_cnt <= hold_cnt + 1;
        end
    end

    typedef struct {
        logic [COUNT_W-1:0] cnt;
        logic [127:0]       bytes;
        bit                 stall;
        int                 stretch_at;
        bit                 exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int t, fin_t, fin_cnt, last_rise, valid_run, byte_no, stall_cnt;
        int stall_bad, line_bad, busy_bad, err_stray, line_act, ack_n;
        logic err_at_fin, busy_at_fin, prev_oe, prev_scl_m, stall_done;
        logic [127:0] tmp;
        int per[$];
        exp_t e;
        string tag;
        tag = $sformatf("v%0d", idx);
        sl_bytes = v.bytes;
        stretch_at = v.stretch_at;
        stuck = 1'b0;
        slave_clr = 1'b1;
        tick();
        slave_clr = 1'b0;
        exp_q.delete();
        tmp = v.bytes;
        if (!v.exp_err) begin
            for (int k = 0; k < int'(v.cnt); k++) begin
                e.d = tmp[7:0];
                e.l = (k == int'(v.cnt) - 1);
                exp_q.push_back(e);
                tmp = tmp >> 8;
            end
        end
        t = 0; fin_t = -1; fin_cnt = 0; last_rise = -1; valid_run = 0; byte_no = 0;
        stall_cnt = 0; stall_bad = 0; line_bad = 0; busy_bad = 0; err_stray = 0;
        line_act = 0; ack_n = 0; err_at_fin = 1'b0; busy_at_fin = 1'b1;
        prev_oe = scl_oe; prev_scl_m = scl_in; stall_done = 1'b0;
        byte_count = v.cnt;
        data_ready = ~v.stall;
        go = 1'b1;
        while (t < 4000 && (fin_t < 0 || t < fin_t + 4)) begin
            tick();
            t++;
            if (t == 1) go = 1'b0;
            if (t == 20) begin go = 1'b1; byte_count = '0; end
            if (t == 21) go = 1'b0;
            if (v.stall && !stall_done && stall_cnt >= 40) begin
                data_ready = 1'b1;
                stall_done = 1'b1;
            end
            if (finish) begin
                fin_cnt++;
                if (fin_t < 0) begin
                    fin_t = t;
                    err_at_fin = error;
                    busy_at_fin = busy;
                end
            end else if (error) begin
                err_stray++;
            end
            if (scl_oe || sda_oe) line_act++;
            if (!v.exp_err && fin_t < 0 && !busy) busy_bad++;
            if (scl_oe && !prev_oe) begin
                if (last_rise >= 0) per.push_back(t - last_rise);
                last_rise = t;
            end
            prev_oe = scl_oe;
            if (scl_in && !prev_scl_m && busy) begin
                if (cur_idx % 9 == 8) begin
                    check($sformatf("%s_ack_byte%0d", tag, cur_idx / 9), int'(sda_oe),
                          int'((cur_idx / 9) < int'(v.cnt) - 1));
                    ack_n++;
                end else if (sda_oe) begin
                    line_bad++;
                end
            end
            prev_scl_m = scl_in;
            if (last && !data_valid) line_bad++;
            if (data_valid) begin
                valid_run++;
                if (v.stall && !stall_done) begin
                    stall_cnt++;
                    if (!scl_oe || exp_q.size() == 0 || data != exp_q[0].d) stall_bad++;
                end
                if (data_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("%s_byte_index", tag), byte_no + 1,
                              v.exp_err ? 0 : int'(v.cnt));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("%s_data%0d", tag, byte_no), int'(data), int'(e.d));
                        check($sformatf("%s_last%0d", tag, byte_no), int'(last), int'(e.l));
                        check($sformatf("%s_valid_cycles%0d", tag, byte_no), valid_run,
                              (v.stall && byte_no == 0) ? 41 : 1);
                    end
                    byte_no++;
                    valid_run = 0;
                end
            end
        end
        check({tag, "_finish_pulses"}, fin_cnt, 1);
        check({tag, "_error_at_finish"}, int'(err_at_fin), int'(v.exp_err));
        check({tag, "_busy_at_finish"}, int'(busy_at_fin), 0);
        check({tag, "_stray_error"}, err_stray, 0);
        check({tag, "_bytes_missing"}, exp_q.size(), 0);
        if (v.exp_err) begin
            check({tag, "_finish_latency"}, fin_t, 1);
            check({tag, "_line_activity"}, line_act, 0);
        end else begin
            check({tag, "_busy_gap"}, busy_bad, 0);
            check({tag, "_line_misuse"}, line_bad, 0);
            check({tag, "_ack_slots"}, ack_n, int'(v.cnt));
            for (int i = 0; i < 8; i++)
                check($sformatf("%s_bit_period%0d", tag, i),
                      (per.size() > i) ? per[i] : -1, (i == v.stretch_at) ? 36 : 16);
        end
        if (v.stall) begin
            check({tag, "_stall_cycles"}, stall_cnt, 40);
            check({tag, "_stall_hold"}, stall_bad, 0);
        end
    endtask

    initial begin
        int t, fall_t, fin_t, dv, quiet;
        logic prev_oe, to_err;
        logic [1:0] to_lines;

        reset = 1'b1; go = 1'b0; byte_count = '0; data_ready = 1'b1;
        stuck = 1'b0; stretch_at = -1; slave_clr = 1'b1; sl_bytes = '0;
        repeat (3) tick();
        check("reset_outputs",
              int'({data, data_valid, last, busy, finish, error, scl_oe, sda_oe}), 0);
        reset = 1'b0;
        tick();

        vecs[0] = '{5'd3,  128'hFF3CA5, 1'b0, -1, 1'b0};
        vecs[1] = '{5'd0,  128'h0,      1'b0, -1, 1'b1};
        vecs[2] = '{5'd17, 128'h0,      1'b0, -1, 1'b1};
        vecs[3] = '{5'd2,  128'hC35A,   1'b1, -1, 1'b0};
        vecs[4] = '{5'd2,  128'h0F96,   1'b0,  3, 1'b0};
        vecs[5] = '{5'd4,  128'h78563412, 1'b0, -1, 1'b0};
        vecs[6] = '{5'd16, 128'h5A02_01F0_DEBC_9A78_5634_1281_7EFF_00C3, 1'b0, -1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            repeat (3) tick();
        end

        // Slave never releases SCL: abort exactly STRETCH_TIMEOUT clocks after the first release.
        stuck = 1'b1; stretch_at = -1; slave_clr = 1'b1;
        tick();
        slave_clr = 1'b0;
        byte_count = 5'd2; go = 1'b1;
        t = 0; fall_t = -1; fin_t = -1; dv = 0; prev_oe = scl_oe; to_err = 1'b0; to_lines = 2'b11;
        while (t < 400 && fin_t < 0) begin
            tick();
            t++;
            if (t == 1) go = 1'b0;
            if (!scl_oe && prev_oe && fall_t < 0) fall_t = t;
            prev_oe = scl_oe;
            if (data_valid) dv++;
            if (finish) begin
                fin_t = t;
                to_err = error;
                to_lines = {scl_oe, sda_oe};
            end
        end
        check("timeout_latency", fin_t - fall_t, STRETCH_TIMEOUT);
        check("timeout_error", int'(to_err), 1);
        check("timeout_lines", int'(to_lines), 0);
        check("timeout_no_valid", dv, 0);
        stuck = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of byte 2 of a 4-byte burst.
        sl_bytes = 128'h44332211; stretch_at = -1; slave_clr = 1'b1;
        tick();
        slave_clr = 1'b0;
        byte_count = 5'd4; data_ready = 1'b1; go = 1'b1;
        t = 0;
        while (t < 1000 && cur_idx < 12) begin
            tick();
            t++;
            if (t == 1) go = 1'b0;
        end
        check("pre_reset_byte", cur_idx / 9, 1);
        check("pre_reset_data", int'(data), 8'h11);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              int'({data, data_valid, last, busy, finish, error, scl_oe, sda_oe}), 0);
        quiet = 0;
        repeat (3) begin
            tick();
            if (finish || error || scl_oe || sda_oe || busy) quiet++;
        end
        check("reset_quiet", quiet, 0);
        reset = 1'b0;
        tick();
        run_vec('{5'd1, 128'h6B, 1'b0, -1, 1'b0}, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
